alarm_scheduler: RTL and testbench

Multi-slot alarm controller that sits beside the real-time clock core and decides when the shared alarm output rings. It holds N programmable alarm times and compares them against the clock's current BCD time once per second. It arbitrates simultaneous matches by lowest index and sequences each ring through ring, snooze and timeout states. It replaces single-register alarm handling; the clock core only supplies time digits.

---
 rtl/alarm_pkg.sv | 25 ++
 rtl/alarm_slot_bank.sv | 74 +++++++
 rtl/alarm_scheduler.sv | 148 ++++++++++++++
 tb/tb_alarm_scheduler.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm scheduler: FSM states, BCD alarm time
// and the slot-index width helper.
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZED = 2'd2
    } state_t;

    typedef struct packed {
        logic [1:0] h1;
        logic [3:0] h0;
        logic [3:0] m1;
        logic [3:0] m0;
    } hhmm_t;

    localparam int SEC_PER_MIN = 60;

    // A single-slot build still needs a one-bit index port.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alarm_slot_bank.sv
// Alarm slot register file with per-slot HH:MM:00 comparators and a
// lowest-index-wins priority encoder.
module alarm_slot_bank
    import alarm_pkg::*;
#(
    parameter int N_ALARMS = 4
) (
    input  logic                             clk_1s,
    input  logic                             reset,
    input  logic [1:0]                       H_in1,
    input  logic [3:0]                       H_in0,
    input  logic [3:0]                       M_in1,
    input  logic [3:0]                       M_in0,
    input  logic [3:0]                       S_in1,
    input  logic [3:0]                       S_in0,
    input  logic                             wr_en,
    input  logic [idx_width(N_ALARMS)-1:0]   wr_idx,
    input  logic [1:0]                       wr_h1,
    input  logic [3:0]                       wr_h0,
    input  logic [3:0]                       wr_m1,
    input  logic [3:0]                       wr_m0,
    input  logic                             wr_on,
    output logic                             match_any,
    output logic [idx_width(N_ALARMS)-1:0]   match_idx,
    output logic [N_ALARMS-1:0]              slot_on
);

    localparam int IDX_W = idx_width(N_ALARMS);

    hhmm_t slot_time [N_ALARMS];
    hhmm_t now_hhmm;
    hhmm_t wr_hhmm;
    logic  top_of_minute;
    logic [N_ALARMS-1:0] eligible;

    assign now_hhmm      = '{h1: H_in1, h0: H_in0, m1: M_in1, m0: M_in0};
    assign wr_hhmm       = '{h1: wr_h1, h0: wr_h0, m1: wr_m1, m0: wr_m0};
    assign top_of_minute = (S_in1 == 4'd0) && (S_in0 == 4'd0);

    always_ff @(posedge clk_1s or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_ALARMS; i++) begin
                slot_time[i] <= '0;
                slot_on[i]   <= 1'b0;
            end
        end else begin
            for (int i = 0; i < N_ALARMS; i++) begin
                if (wr_en && (wr_idx == IDX_W'(i))) begin
                    slot_time[i] <= wr_hhmm;
                    slot_on[i]   <= wr_on;
                end
            end
        end
    end

    // Comparators read the registered slots, so a same-edge write only counts next cycle.
    always_comb begin
        for (int i = 0; i < N_ALARMS; i++) begin
            eligible[i] = slot_on[i] && top_of_minute && (slot_time[i] == now_hhmm);
        end
    end

    always_comb begin
        match_any = 1'b0;
        match_idx = '0;
        for (int i = N_ALARMS - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                match_any = 1'b1;
                match_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/alarm_scheduler.sv
// Multi-slot alarm controller: picks the winning slot at HH:MM:00 and sequences
// the shared alarm through ringing, snoozing and auto-stop.
//
//   state   | meaning
//   IDLE    | waiting for a slot match, alarm low
//   RINGING | alarm high, ring_cnt counts seconds towards auto-stop
//   SNOOZED | alarm low, snz_cnt counts down to the next ring
module alarm_scheduler
    import alarm_pkg::*;
#(
    parameter int N_ALARMS       = 4,
    parameter int SNOOZE_MIN     = 5,
    parameter int RING_TIMEOUT_S = 60,
    parameter int MAX_SNOOZE     = 3
) (
    input  logic                             clk_1s,
    input  logic                             reset,
    input  logic [1:0]                       H_in1,
    input  logic [3:0]                       H_in0,
    input  logic [3:0]                       M_in1,
    input  logic [3:0]                       M_in0,
    input  logic [3:0]                       S_in1,
    input  logic [3:0]                       S_in0,
    input  logic                             wr_en,
    input  logic [idx_width(N_ALARMS)-1:0]   wr_idx,
    input  logic [1:0]                       wr_h1,
    input  logic [3:0]                       wr_h0,
    input  logic [3:0]                       wr_m1,
    input  logic [3:0]                       wr_m0,
    input  logic                             wr_on,
    input  logic                             snooze,
    input  logic                             stop,
    output logic                             alarm,
    output logic [idx_width(N_ALARMS)-1:0]   active_idx,
    output logic                             snoozed,
    output logic [1:0]                       snooze_left
);

    localparam int IDX_W      = idx_width(N_ALARMS);
    localparam int SNZ_CYCLES = SNOOZE_MIN * SEC_PER_MIN;
    localparam int SNZ_W      = $clog2(SNZ_CYCLES);

    localparam logic [SNZ_W-1:0] SNZ_LOAD    = SNZ_W'(SNZ_CYCLES - 1);
    localparam logic [7:0]       RING_LAST   = 8'(RING_TIMEOUT_S - 1);
    localparam logic [1:0]       SNOOZE_INIT = 2'(MAX_SNOOZE);

    state_t               state;
    logic [7:0]           ring_cnt;
    logic [SNZ_W-1:0]     snz_cnt;
    logic                 match_any;
    logic [IDX_W-1:0]     match_idx;
    logic [N_ALARMS-1:0]  slot_on;
    logic                 active_off;

    alarm_slot_bank #(
        .N_ALARMS (N_ALARMS)
    ) u_slot_bank (
        .clk_1s    (clk_1s),
        .reset     (reset),
        .H_in1     (H_in1),
        .H_in0     (H_in0),
        .M_in1     (M_in1),
        .M_in0     (M_in0),
        .S_in1     (S_in1),
        .S_in0     (S_in0),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_h1     (wr_h1),
        .wr_h0     (wr_h0),
        .wr_m1     (wr_m1),
        .wr_m0     (wr_m0),
        .wr_on     (wr_on),
        .match_any (match_any),
        .match_idx (match_idx),
        .slot_on   (slot_on)
    );

    // Disabling the owning slot ends the ring on the write edge itself; the
    // registered on bit is a backstop so the FSM never keeps a disabled owner.
    assign active_off = (wr_en && (wr_idx == active_idx) && !wr_on) || !slot_on[active_idx];

    always_ff @(posedge clk_1s or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            alarm       <= 1'b0;
            active_idx  <= '0;
            snoozed     <= 1'b0;
            snooze_left <= '0;
            ring_cnt    <= '0;
            snz_cnt     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (match_any) begin
                        state       <= RINGING;
                        alarm       <= 1'b1;
                        active_idx  <= match_idx;
                        ring_cnt    <= '0;
                        snooze_left <= SNOOZE_INIT;
                    end
                end

                RINGING: begin
                    if (active_off || stop) begin
                        state <= IDLE;
                        alarm <= 1'b0;
                    end else if (snooze) begin
                        alarm <= 1'b0;
                        if (snooze_left != 2'd0) begin
                            state       <= SNOOZED;
                            snoozed     <= 1'b1;
                            snooze_left <= snooze_left - 2'd1;
                            snz_cnt     <= SNZ_LOAD;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (ring_cnt == RING_LAST) begin
                        state <= IDLE;
                        alarm <= 1'b0;
                    end else begin
                        ring_cnt <= ring_cnt + 8'd1;
                    end
                end

                SNOOZED: begin
                    if (active_off || stop) begin
                        state   <= IDLE;
                        snoozed <= 1'b0;
                    end else if (snz_cnt == '0) begin
                        state    <= RINGING;
                        alarm    <= 1'b1;
                        snoozed  <= 1'b0;
                        ring_cnt <= '0;
                    end else begin
                        snz_cnt <= snz_cnt - 1'b1;
                    end
                end

                default: begin
                    state   <= IDLE;
                    alarm   <= 1'b0;
                    snoozed <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alarm_scheduler.sv
// Directed bench for alarm_scheduler with default parameters (4 slots, 5 min
// snooze, 60 s ring timeout, 3 snoozes).
module tb_alarm_scheduler;

    logic       clk_1s = 1'b0;
    logic       reset;
    logic [1:0] H_in1;
    logic [3:0] H_in0, M_in1, M_in0, S_in1, S_in0;
    logic       wr_en;
    logic [1:0] wr_idx;
    logic [1:0] wr_h1;
    logic [3:0] wr_h0, wr_m1, wr_m0;
    logic       wr_on, snooze, stop;
    logic       alarm;
    logic [1:0] active_idx;
    logic       snoozed;
    logic [1:0] snooze_left;

    int errors = 0;
    int checks = 0;

    alarm_scheduler #(
        .N_ALARMS       (4),
        .SNOOZE_MIN     (5),
        .RING_TIMEOUT_S (60),
        .MAX_SNOOZE     (3)
    ) dut (
        .clk_1s      (clk_1s),
        .reset       (reset),
        .H_in1       (H_in1),
        .H_in0       (H_in0),
        .M_in1       (M_in1),
        .M_in0       (M_in0),
        .S_in1       (S_in1),
        .S_in0       (S_in0),
        .wr_en       (wr_en),
        .wr_idx      (wr_idx),
        .wr_h1       (wr_h1),
        .wr_h0       (wr_h0),
        .wr_m1       (wr_m1),
        .wr_m0       (wr_m0),
        .wr_on       (wr_on),
        .snooze      (snooze),
        .stop        (stop),
        .alarm       (alarm),
        .active_idx  (active_idx),
        .snoozed     (snoozed),
        .snooze_left (snooze_left)
    );

    always #5 clk_1s = ~clk_1s;

    task automatic step();
        @(posedge clk_1s);
        @(negedge clk_1s);
    endtask

    task automatic set_time(input logic [1:0] h1, input logic [3:0] h0, input logic [3:0] m1,
                            input logic [3:0] m0, input logic [3:0] s1, input logic [3:0] s0);
        H_in1 = h1; H_in0 = h0; M_in1 = m1; M_in0 = m0; S_in1 = s1; S_in0 = s0;
    endtask

    task automatic write_slot(input logic [1:0] idx, input logic [1:0] h1, input logic [3:0] h0,
                              input logic [3:0] m1, input logic [3:0] m0, input logic on);
        wr_en = 1'b1; wr_idx = idx; wr_h1 = h1; wr_h0 = h0; wr_m1 = m1; wr_m0 = m0; wr_on = on;
        step();
        wr_en = 1'b0;
    endtask

    // Presents 07:30:00 for one edge, then parks the time at 07:30:05.
    task automatic trigger_0730();
        set_time(2'd0, 4'd7, 4'd3, 4'd0, 4'd0, 4'd0);
        step();
        set_time(2'd0, 4'd7, 4'd3, 4'd0, 4'd0, 4'd5);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++;
        if (alarm !== 1'b0) begin errors++; $display("FAIL reset_alarm: got %b want 0", alarm); end
        checks++;
        if (active_idx !== 2'd0) begin errors++; $display("FAIL reset_active_idx: got %0d want 0", active_idx); end
        checks++;
        if (snoozed !== 1'b0) begin errors++; $display("FAIL reset_snoozed: got %b want 0", snoozed); end
        checks++;
        if (snooze_left !== 2'd0) begin errors++; $display("FAIL reset_snooze_left: got %0d want 0", snooze_left); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic_match();
        set_time(2'd0, 4'd7, 4'd2, 4'd9, 4'd5, 4'd9);
        write_slot(2'd2, 2'd0, 4'd7, 4'd3, 4'd0, 1'b1);
        checks++;
        if (alarm !== 1'b0) begin errors++; $display("FAIL basic_pre_alarm: got %b want 0", alarm); end
        set_time(2'd0, 4'd7, 4'd3, 4'd0, 4'd0, 4'd0);
        step();
        checks++;
        if (alarm !== 1'b1) begin errors++; $display("FAIL basic_alarm_rise: got %b want 1", alarm); end
        checks++;
        if (active_idx !== 2'd2) begin errors++; $display("FAIL basic_active_idx: got %0d want 2", active_idx); end
        checks++;
        if (snooze_left !== 2'd3) begin errors++; $display("FAIL basic_snooze_left: got %0d want 3", snooze_left); end
        set_time(2'd0, 4'd7, 4'd3, 4'd0, 4'd0, 4'd1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        checks++;
        if (alarm !== 1'b0) begin errors++; $display("FAIL basic_stop: got %b want 0", alarm); end
    endtask

    task automatic test_write_same_cycle();
        set_time(2'd0, 4'd8, 4'd0, 4'd0, 4'd0, 4'd0);
        write_slot(2'd0, 2'd0, 4'd8, 4'd0, 4'd0, 1'b1);
        checks++;
        if (alarm !== 1'b0) begin errors++; $display("FAIL same_cycle_write: got %b want 0", alarm); end
        step();
        checks++;
        if (alarm !== 1'b1) begin errors++; $display("FAIL written_slot_visible: got %b want 1", alarm); end
        checks++;
        if (active_idx !== 2'd0) begin errors++; $display("FAIL written_slot_idx: got %0d want 0", active_idx); end
        set_time(2'd0, 4'd8, 4'd0, 4'd0, 4'd0, 4'd1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        write_slot(2'd0, 2'd0, 4'd8, 4'd0, 4'd0, 1'b0);
    endtask

    task automatic test_priority();
        set_time(2'd0, 4'd5, 4'd5, 4'd9, 4'd3, 4'd0);
        write_slot(2'd1, 2'd0, 4'd6, 4'd0, 4'd0, 1'b1);
        write_slot(2'd3, 2'd0, 4'd6, 4'd0, 4'd0, 1'b1);
        set_time(2'd0, 4'd6, 4'd0, 4'd0, 4'd0, 4'd0);
        step();
        checks++;
        if (active_idx !== 2'd1) begin errors++; $display("FAIL priority_idx: got %0d want 1", active_idx); end
        checks++;
        if (alarm !== 1'b1) begin errors++; $display("FAIL priority_alarm: got %b want 1", alarm); end
        set_time(2'd0, 4'd6, 4'd0, 4'd0, 4'd0, 4'd1);
        write_slot(2'd3, 2'd0, 4'd6, 4'd0, 4'd1, 1'b1);
        set_time(2'd0, 4'd6, 4'd0, 4'd1, 4'd0, 4'd0);
        step();
        checks++;
        if (active_idx !== 2'd1 || alarm !== 1'b1) begin
            errors++; $display("FAIL priority_drop_new: got idx=%0d alarm=%b want idx=1 alarm=1", active_idx, alarm);
        end
        set_time(2'd0, 4'd6, 4'd0, 4'd1, 4'd0, 4'd1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        step();
        checks++;
        if (alarm !== 1'b0) begin errors++; $display("FAIL priority_not_queued: got %b want 0", alarm); end
        write_slot(2'd1, 2'd0, 4'd6, 4'd0, 4'd0, 1'b0);
        write_slot(2'd3, 2'd0, 4'd6, 4'd0, 4'd1, 1'b0);
    endtask

    task automatic test_timeout();
        int highs;
        trigger_0730();
        highs = 0;
        while (alarm === 1'b1 && highs < 100) begin
            highs++;
            step();
        end
        checks++;
        if (highs != 60) begin errors++; $display("FAIL timeout_high_cycles: got %0d want 60", highs); end
        set_time(2'd0, 4'd7, 4'd3, 4'd1, 4'd0, 4'd0);
        step();
        checks++;
        if (alarm !== 1'b0) begin errors++; $display("FAIL timeout_no_retrigger: got %b want 0", alarm); end
        set_time(2'd0, 4'd7, 4'd3, 4'd1, 4'd0, 4'd1);
    endtask

    task automatic test_snooze();
        int lows;
        trigger_0730();
        repeat (10) step();
        checks++;
        if (alarm !== 1'b1) begin errors++; $display("FAIL snooze_ringing_at_10: got %b want 1", alarm); end
        for (int k = 0; k < 3; k++) begin
            snooze = 1'b1;
            step();
            snooze = 1'b0;
            checks++;
            if (alarm !== 1'b0 || snoozed !== 1'b1) begin
                errors++; $display("FAIL snooze_enter_%0d: got alarm=%b snoozed=%b want 0/1", k, alarm, snoozed);
            end
            checks++;
            if (snooze_left !== 2'(2 - k)) begin
                errors++; $display("FAIL snooze_left_%0d: got %0d want %0d", k, snooze_left, 2 - k);
            end
            lows = 0;
            while (alarm === 1'b0 && lows < 400) begin
                lows++;
                step();
            end
            checks++;
            if (lows != 300) begin errors++; $display("FAIL snooze_low_cycles_%0d: got %0d want 300", k, lows); end
            checks++;
            if (active_idx !== 2'd2 || snoozed !== 1'b0) begin
                errors++; $display("FAIL snooze_rering_%0d: got idx=%0d snoozed=%b want 2/0", k, active_idx, snoozed);
            end
        end
        snooze = 1'b1;
        step();
        snooze = 1'b0;
        step();
        checks++;
        if (alarm !== 1'b0 || snoozed !== 1'b0) begin
            errors++; $display("FAIL snooze_exhausted: got alarm=%b snoozed=%b want 0/0", alarm, snoozed);
        end
    endtask

    task automatic test_stop_and_snooze();
        trigger_0730();
        step();
        stop = 1'b1;
        snooze = 1'b1;
        step();
        stop = 1'b0;
        snooze = 1'b0;
        checks++;
        if (alarm !== 1'b0 || snoozed !== 1'b0) begin
            errors++; $display("FAIL stop_wins: got alarm=%b snoozed=%b want 0/0", alarm, snoozed);
        end
        checks++;
        if (snooze_left !== 2'd3) begin errors++; $display("FAIL stop_wins_left: got %0d want 3", snooze_left); end
    endtask

    task automatic test_cancel_write();
        logic rose;
        trigger_0730();
        snooze = 1'b1;
        step();
        snooze = 1'b0;
        checks++;
        if (snoozed !== 1'b1) begin errors++; $display("FAIL cancel_snoozed: got %b want 1", snoozed); end
        write_slot(2'd2, 2'd0, 4'd7, 4'd3, 4'd0, 1'b0);
        checks++;
        if (snoozed !== 1'b0 || alarm !== 1'b0) begin
            errors++; $display("FAIL cancel_to_idle: got snoozed=%b alarm=%b want 0/0", snoozed, alarm);
        end
        rose = 1'b0;
        repeat (320) begin
            step();
            if (alarm !== 1'b0) rose = 1'b1;
        end
        checks++;
        if (rose !== 1'b0) begin errors++; $display("FAIL cancel_no_ring: got %b want 0", rose); end
    endtask

    task automatic test_write_keep();
        set_time(2'd0, 4'd7, 4'd3, 4'd0, 4'd0, 4'd1);
        write_slot(2'd2, 2'd0, 4'd7, 4'd3, 4'd0, 1'b1);
        trigger_0730();
        write_slot(2'd2, 2'd0, 4'd9, 4'd0, 4'd0, 1'b1);
        checks++;
        if (alarm !== 1'b1 || active_idx !== 2'd2) begin
            errors++; $display("FAIL write_on_keeps_ring: got alarm=%b idx=%0d want 1/2", alarm, active_idx);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic test_reset_mid_snooze();
        set_time(2'd0, 4'd7, 4'd3, 4'd0, 4'd0, 4'd1);
        write_slot(2'd2, 2'd0, 4'd7, 4'd3, 4'd0, 1'b1);
        trigger_0730();
        snooze = 1'b1;
        step();
        snooze = 1'b0;
        checks++;
        if (snoozed !== 1'b1 || active_idx !== 2'd2) begin
            errors++; $display("FAIL pre_reset_snooze: got snoozed=%b idx=%0d want 1/2", snoozed, active_idx);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (alarm !== 1'b0 || snoozed !== 1'b0 || active_idx !== 2'd0) begin
            errors++; $display("FAIL async_reset: got alarm=%b snoozed=%b idx=%0d want 0/0/0", alarm, snoozed, active_idx);
        end
        @(negedge clk_1s);
        reset = 1'b0;
        set_time(2'd0, 4'd7, 4'd3, 4'd0, 4'd0, 4'd0);
        step();
        checks++;
        if (alarm !== 1'b0) begin errors++; $display("FAIL reset_clears_slots: got %b want 0", alarm); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        wr_en = 1'b0; wr_idx = '0; wr_h1 = '0; wr_h0 = '0; wr_m1 = '0; wr_m0 = '0; wr_on = 1'b0;
        snooze = 1'b0; stop = 1'b0;
        set_time(2'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
        @(negedge clk_1s);
        test_reset();
        test_basic_match();
        test_write_same_cycle();
        test_priority();
        test_timeout();
        test_snooze();
        test_stop_and_snooze();
        test_cancel_write();
        test_write_keep();
        test_reset_mid_snooze();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
